cpu_mc: RTL and testbench

CPU_MC -- requirements
Module: cpu_mc

---
 rtl/cpu_mc.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cpu_mc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// cpu_mc -- small multi-cycle CPU core.
//
// Each instruction goes FETCH -> EXEC (-> MEM for loads/stores) -> FETCH.
// A zero-wait ALU/branch instruction therefore takes two cycles, and a
// zero-wait memory access takes three.
//
// Instruction fields:
//   [31:24] opcode   [23:16] dest / branch offset   [15:8] src1   [7:0] src2 / imm
// Register indices use the low REG_AW bits of each field; imm and offset are
// sign-extended. MOV copies src1 into dest.
//
// Optional build macro CPU_MC_TRAP_EN: when defined, an undefined opcode sets
// ILLEGAL and parks the core in HALT until RESET. When it is not defined,
// undefined opcodes retire as NOPs and ILLEGAL is tied low.

module cpu_mc #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              INS_BUSYWAIT,
  output logic [PC_W-1:0]   PC,
  output logic              READ,
  output logic              WRITE,
  output logic [DATA_W-1:0] ADDRESS,
  output logic [DATA_W-1:0] WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              BUSYWAIT,
  output logic              ILLEGAL
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;
  localparam logic [7:0] OP_BNE   = 8'h0C;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  // Architectural and control state
  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef CPU_MC_TRAP_EN
  logic              illegal_q, illegal_d;
`endif

  // Decode of the latched instruction
  logic [7:0]        opcode_s;
  logic [REG_AW-1:0] dst_idx_s;
  logic [REG_AW-1:0] src1_idx_s;
  logic [REG_AW-1:0] src2_idx_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic [PC_W-1:0]   off_ext_s;
  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;
  logic [DATA_W-1:0] dst_val_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   br_tgt_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              unused_ir_s;

  assign opcode_s   = ir_q[31:24];
  assign dst_idx_s  = ir_q[16 +: REG_AW];
  assign src1_idx_s = ir_q[8 +: REG_AW];
  assign src2_idx_s = ir_q[0 +: REG_AW];
  assign imm_ext_s  = DATA_W'($signed(ir_q[7:0]));
  assign off_ext_s  = PC_W'($signed(ir_q[23:16]));

  // All operands are read from the pre-instruction register file, so an
  // instruction that overwrites one of its own sources still sees the old value.
  assign op1_s     = regs_q[src1_idx_s];
  assign op2_s     = regs_q[src2_idx_s];
  assign dst_val_s = regs_q[dst_idx_s];

  // The sequential PC and the branch/jump target, both wrapping modulo 2**PC_W
  assign pc_inc_s = pc_q + PC_W'(32'd4);
  assign br_tgt_s = pc_inc_s + {off_ext_s[PC_W-3:0], 2'b00};

  // Field bits above REG_AW only matter for wider register files
  assign unused_ir_s = ^ir_q;

  // Compute the register-write result for the LOADI/MOV/ALU group
  always_comb begin
    alu_res_s = {DATA_W{1'b0}};
    case (opcode_s)
      OP_LOADI: alu_res_s = imm_ext_s;
      OP_MOV:   alu_res_s = op1_s;
      OP_ADD:   alu_res_s = op1_s + op2_s;
      OP_SUB:   alu_res_s = op1_s + (~op2_s + {{(DATA_W-1){1'b0}}, 1'b1});
      OP_AND:   alu_res_s = op1_s & op2_s;
      OP_OR:    alu_res_s = op1_s | op2_s;
      default:  alu_res_s = {DATA_W{1'b0}};
    endcase
  end

  // Next-state logic: FSM sequencing, PC update, register writes, memory strobes
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    read_d  = read_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef CPU_MC_TRAP_EN
    illegal_d = illegal_q;
`endif

    case (state_q)
      S_FETCH: begin
        if (!INS_BUSYWAIT) begin
          ir_d    = INSTRUCTION;
          state_d = S_EXEC;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        case (opcode_s)
          OP_LOADI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            regs_d[dst_idx_s] = alu_res_s;
            pc_d              = pc_inc_s;
            state_d           = S_FETCH;
          end
          OP_J: begin
            pc_d    = br_tgt_s;
            state_d = S_FETCH;
          end
          OP_BEQ: begin
            if (op1_s == op2_s) begin
              pc_d = br_tgt_s;
            end else begin
              pc_d = pc_inc_s;
            end
            state_d = S_FETCH;
          end
          OP_BNE: begin
            if (op1_s != op2_s) begin
              pc_d = br_tgt_s;
            end else begin
              pc_d = pc_inc_s;
            end
            state_d = S_FETCH;
          end
          OP_LWD: begin
            addr_d  = op2_s;
            wdata_d = dst_val_s;
            read_d  = 1'b1;
            state_d = S_MEM;
          end
          OP_LWI: begin
            addr_d  = imm_ext_s;
            wdata_d = dst_val_s;
            read_d  = 1'b1;
            state_d = S_MEM;
          end
          OP_SWD: begin
            addr_d  = op2_s;
            wdata_d = dst_val_s;
            write_d = 1'b1;
            state_d = S_MEM;
          end
          OP_SWI: begin
            addr_d  = imm_ext_s;
            wdata_d = dst_val_s;
            write_d = 1'b1;
            state_d = S_MEM;
          end
          default: begin
`ifdef CPU_MC_TRAP_EN
            illegal_d = 1'b1;
            state_d   = S_HALT;
`else
            pc_d    = pc_inc_s;
            state_d = S_FETCH;
`endif
          end
        endcase
      end

      S_MEM: begin
        // Strobes, ADDRESS and WRITEDATA are held until the memory drops BUSYWAIT
        if (!BUSYWAIT) begin
          if (read_q) begin
            regs_d[dst_idx_s] = MEM_READDATA;
          end else begin
            regs_d = regs_q;
          end
          pc_d    = pc_inc_s;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_MEM;
        end
      end

      S_HALT: begin
`ifdef CPU_MC_TRAP_EN
        state_d = S_HALT;
`else
        state_d = S_FETCH;
`endif
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      pc_q    <= {PC_W{1'b0}};
      ir_q    <= 32'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= {DATA_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
`ifdef CPU_MC_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      read_q  <= read_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      regs_q  <= regs_d;
`ifdef CPU_MC_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign PC        = pc_q;
  assign READ      = read_q;
  assign WRITE     = write_q;
  assign ADDRESS   = addr_q;
  assign WRITEDATA = wdata_q;
`ifdef CPU_MC_TRAP_EN
  assign ILLEGAL   = illegal_q;
`else
  assign ILLEGAL   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_mc.sv
// Testbench for cpu_mc (DATA_W=16). An instruction-level reference model
// predicts the PC, memory strobes, address and store data of every
// instruction. The bench plays instruction and data memory, inserting random
// fetch and data stalls.
module tb_cpu_mc;

  localparam int DW = 16;
  localparam int RAW = 3;
  localparam int PW = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [31:0]   INSTRUCTION;
  logic          INS_BUSYWAIT;
  logic [PW-1:0] PC;
  logic          READ, WRITE;
  logic [DW-1:0] ADDRESS, WRITEDATA, MEM_READDATA;
  logic          BUSYWAIT;
  logic          ILLEGAL;

  cpu_mc #(.DATA_W(DW), .REG_AW(RAW), .PC_W(PW)) u_dut (
    .CLK(CLK), .RESET(RESET), .INSTRUCTION(INSTRUCTION), .INS_BUSYWAIT(INS_BUSYWAIT),
    .PC(PC), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .BUSYWAIT(BUSYWAIT), .ILLEGAL(ILLEGAL)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state
  logic [DW-1:0] m_reg [8];
  logic [PW-1:0] m_pc;
  int            read_cycles;
  logic [DW-1:0] last_wd, last_addr;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sx(input logic [7:0] b);
    return {{(DW-8){b[7]}}, b};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_pc = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    INS_BUSYWAIT = 1'b0;
    BUSYWAIT = 1'b0;
    step();
    step();
    RESET = 1'b0;
    model_reset();
  endtask

  // Run one instruction: fw fetch stalls, mw data stalls; abort_at >= 0 asserts
  // RESET at that MEM cycle instead of completing the access.
  task automatic exec_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic [DW-1:0] rdata, input int abort_at);
    logic [7:0]    op;
    int            d, s1, s2;
    logic [DW-1:0] a, b, res, exp_addr, exp_wd;
    logic [PW-1:0] nxt, tgt, offx;
    bit            wr_reg, is_mem, is_ld, undef;
    op = ins[31:24];
    d = int'(ins[18:16]);
    s1 = int'(ins[10:8]);
    s2 = int'(ins[2:0]);
    a = m_reg[s1];
    b = m_reg[s2];
    nxt = m_pc + 32'd4;
    offx = {{(PW-8){ins[23]}}, ins[23:16]};
    tgt = m_pc + 32'd4 + offx * 32'd4;
    wr_reg = 0; is_mem = 0; is_ld = 0; undef = 0;
    res = '0; exp_addr = '0; exp_wd = m_reg[d];
    case (op)
      8'h00: begin res = sx(ins[7:0]); wr_reg = 1; end
      8'h01: begin res = a; wr_reg = 1; end
      8'h02: begin res = a + b; wr_reg = 1; end
      8'h03: begin res = a - b; wr_reg = 1; end
      8'h04: begin res = a & b; wr_reg = 1; end
      8'h05: begin res = a | b; wr_reg = 1; end
      8'h06: nxt = tgt;
      8'h07: if (a == b) nxt = tgt;
      8'h0C: if (a != b) nxt = tgt;
      8'h08: begin is_mem = 1; is_ld = 1; exp_addr = b; end
      8'h09: begin is_mem = 1; is_ld = 1; exp_addr = sx(ins[7:0]); end
      8'h0A: begin is_mem = 1; exp_addr = b; end
      8'h0B: begin is_mem = 1; exp_addr = sx(ins[7:0]); end
      default: undef = 1;
    endcase

    // Fetch, with stalls carrying garbage on INSTRUCTION
    for (int i = 0; i < fw; i++) begin
      INS_BUSYWAIT = 1'b1;
      INSTRUCTION = $urandom;
      step();
      check_value("fetch_stall_pc", PC, m_pc);
    end
    INS_BUSYWAIT = 1'b0;
    INSTRUCTION = ins;
    step();
    check_value("exec_pc", PC, m_pc);
    INS_BUSYWAIT = 1'($urandom_range(0, 1));
    INSTRUCTION = $urandom;
    step();

`ifdef CPU_MC_TRAP_EN
    if (undef) begin
      check_value("trap_illegal", ILLEGAL, 1);
      check_value("trap_pc", PC, m_pc);
      for (int k = 0; k < 3; k++) begin
        INS_BUSYWAIT = 1'b0;
        INSTRUCTION = {8'h00, 24'($urandom)};
        step();
        check_value("halt_pc", PC, m_pc);
        check_value("halt_illegal", ILLEGAL, 1);
        check_value("halt_strobes", {READ, WRITE}, 2'b00);
      end
      return;
    end
`endif

    if (!is_mem) begin
      check_value("next_pc", PC, nxt);
      check_value("strobes_idle", {READ, WRITE}, 2'b00);
      check_value("illegal_low", ILLEGAL, 0);
      if (wr_reg) m_reg[d] = res;
      m_pc = nxt;
      return;
    end

    // Memory phase
    check_value("mem_read", READ, is_ld);
    check_value("mem_write", WRITE, !is_ld);
    check_value("mem_addr", ADDRESS, exp_addr);
    check_value("mem_wdata", WRITEDATA, exp_wd);
    last_addr = ADDRESS;
    last_wd = WRITEDATA;
    read_cycles = (READ === 1'b1) ? 1 : 0;
    for (int j = 0; j <= mw; j++) begin
      if (j == abort_at) begin
        RESET = 1'b1;
        BUSYWAIT = 1'b0;
        MEM_READDATA = rdata;
        step();
        RESET = 1'b0;
        check_value("abort_strobes", {READ, WRITE}, 2'b00);
        check_value("abort_pc", PC, 0);
        model_reset();
        return;
      end
      if (j < mw) begin
        BUSYWAIT = 1'b1;
        MEM_READDATA = $urandom;
        step();
        check_value("stall_strobes", {READ, WRITE}, {is_ld, !is_ld});
        check_value("stall_addr", ADDRESS, exp_addr);
        check_value("stall_wdata", WRITEDATA, exp_wd);
        check_value("stall_pc", PC, m_pc);
        if (READ === 1'b1) read_cycles++;
      end else begin
        BUSYWAIT = 1'b0;
        MEM_READDATA = rdata;
        step();
        check_value("mem_done_strobes", {READ, WRITE}, 2'b00);
        check_value("mem_done_pc", PC, nxt);
      end
    end
    BUSYWAIT = 1'b0;
    if (is_ld) m_reg[d] = rdata;
    m_pc = nxt;
  endtask

  // Store every register so the model's register file is compared
  task automatic dump_regs();
    for (int r = 0; r < 8; r++) begin
      exec_instr({8'h0B, 5'($urandom), 3'(r), 8'($urandom), 8'($urandom)},
                 0, $urandom_range(0, 1), '0, -1);
    end
  endtask

  task automatic branch_case(input logic [7:0] op, input logic [7:0] v2, input logic [31:0] exp_pc, input string tag);
    do_reset();
    exec_instr({8'h00, 8'h01, 8'h00, 8'h05}, 0, 0, '0, -1);
    exec_instr({8'h00, 8'h02, 8'h00, v2}, 0, 0, '0, -1);
    exec_instr({op, 8'hFE, 8'h01, 8'h02}, 0, 0, '0, -1);
    check_value(tag, PC, exp_pc);
  endtask

  initial begin
    logic [31:0] ins;
    logic [7:0]  op;
    logic [DW-1:0] rd_val;
    int c0;
    logic [PW-1:0] pc0;

    RESET = 1'b1;
    INSTRUCTION = $urandom;
    INS_BUSYWAIT = 1'b0;
    BUSYWAIT = 1'b1;
    MEM_READDATA = $urandom;
    step();
    step();
    check_value("rst_pc", PC, 0);
    check_value("rst_strobes", {READ, WRITE}, 2'b00);
    check_value("rst_addr", ADDRESS, 0);
    check_value("rst_wdata", WRITEDATA, 0);
    check_value("rst_illegal", ILLEGAL, 0);
    RESET = 1'b0;
    BUSYWAIT = 1'b0;
    model_reset();
    dump_regs();

    // LOADI r1,5; LOADI r2,3; SUB r3,r1,r2
    do_reset();
    c0 = cyc;
    exec_instr({8'h00, 8'h01, 8'h00, 8'h05}, 0, 0, '0, -1);
    exec_instr({8'h00, 8'h02, 8'h00, 8'h03}, 0, 0, '0, -1);
    exec_instr({8'h03, 8'h03, 8'h01, 8'h02}, 0, 0, '0, -1);
    check_value("sub_cycles", cyc - c0, 6);
    check_value("sub_pc", PC, 12);
    exec_instr({8'h0B, 8'h03, 8'h00, 8'h40}, 0, 0, '0, -1);
    check_value("sub_r3", last_wd, 2);

    // Branches at PC=8 with offset -2
    branch_case(8'h07, 8'h05, 32'd4, "beq_taken");
    branch_case(8'h07, 8'h06, 32'd12, "beq_untaken");
    branch_case(8'h0C, 8'h05, 32'd12, "bne_untaken");
    branch_case(8'h0C, 8'h06, 32'd4, "bne_taken");

    // LWI r4,0x10 with three data stalls
    rd_val = 16'($urandom);
    exec_instr({8'h09, 8'h04, 8'h00, 8'h10}, 1, 3, rd_val, -1);
    check_value("lwi_read_cycles", read_cycles, 4);
    check_value("lwi_addr", last_addr, 16'h0010);
    exec_instr({8'h0B, 8'h04, 8'h00, 8'h20}, 0, 0, '0, -1);
    check_value("lwi_r4", last_wd, rd_val);

    // 16-bit wrap: 0xFFFF + 2, then store the sum
    exec_instr({8'h00, 8'h01, 8'h00, 8'hFF}, 0, 0, '0, -1);
    exec_instr({8'h00, 8'h02, 8'h00, 8'h02}, 0, 0, '0, -1);
    exec_instr({8'h02, 8'h03, 8'h01, 8'h02}, 0, 0, '0, -1);
    exec_instr({8'h0A, 8'h03, 8'h00, 8'h02}, 0, 1, '0, -1);
    check_value("add_wrap_wdata", last_wd, 16'h0001);

    // Random programme with random fetch and data stalls
    for (int n = 0; n < 400; n++) begin
      op = 8'($urandom_range(0, 12));
`ifndef CPU_MC_TRAP_EN
      if ($urandom_range(0, 15) == 0) op = 8'($urandom_range(13, 255));
`endif
      ins = {op, 24'($urandom)};
      exec_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 16'($urandom), -1);
      if (n % 100 == 99) dump_regs();
    end
    dump_regs();

    // Reset in the middle of a load: no write, strobes dropped, PC cleared
    exec_instr({8'h00, 8'h05, 8'h00, 8'h33}, 0, 0, '0, -1);
    exec_instr({8'h09, 8'h05, 8'h00, 8'h20}, 0, 4, 16'hBEEF, 2);
    dump_regs();

    // Undefined opcode
    pc0 = m_pc;
    exec_instr({8'hFF, 24'h000000}, 0, 0, '0, -1);
`ifdef CPU_MC_TRAP_EN
    check_value("undef_illegal", ILLEGAL, 1);
    check_value("undef_pc_frozen", PC, pc0);
    do_reset();
`else
    check_value("undef_illegal", ILLEGAL, 0);
    check_value("undef_pc_adv", PC, pc0 + 32'd4);
`endif
    dump_regs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
